// File: rtl/lcd_hd44780_tx.sv
// HD44780 character-LCD transmit engine: power-on init sequence, then one
// command/data byte per valid/ready handshake with EN setup/pulse/hold/exec timing.
module lcd_hd44780_tx #(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       lcd_on,
    output logic       lcd_blon
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_T = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_EXEC, T_EXEC_LONG));
    localparam int CW = $clog2(MAX_T) + 1;

    // Counters hold "cycles left minus one"; the waits that end in IDLE are one
    // shorter so cmd_ready is already high on the edge the wait expires.
    localparam logic [CW-1:0] C_PWRUP  = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] C_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_PULSE  = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] C_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_EXEC   = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] C_EXEC_I = CW'(T_EXEC - 2);
    localparam logic [CW-1:0] C_LONG   = CW'(T_EXEC_LONG - 1);
    localparam logic [CW-1:0] C_LONG_I = CW'(T_EXEC_LONG - 2);
    localparam logic [2:0]    ROM_LEN  = 3'd6;

    // LOAD is resolved on the same edge that leaves PWRUP/WAIT, so init bytes
    // follow each other with no extra cycle.
    typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_e;

    function automatic logic [7:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          en_q, en_d, rs_q, rs_d, ready_q, ready_d, done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic          is_long, is_last;

    assign is_long = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign is_last = (idx_q == ROM_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        idx_d   = idx_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = ready_q;
        done_d  = done_q;
        case (state_q)
            PWRUP: if (cnt_q == '0) begin
                state_d = SETUP;
                cnt_d   = C_SETUP;
                rs_d    = 1'b0;
                data_d  = init_rom(idx_q);
                idx_d   = idx_q + 3'd1;
            end
            SETUP: if (cnt_q == '0) begin
                state_d = PULSE;
                cnt_d   = C_PULSE;
                en_d    = 1'b1;
            end
            PULSE: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = C_HOLD;
                en_d    = 1'b0;
            end
            HOLD: if (cnt_q == '0) begin
                state_d = WAIT;
                if (is_long) cnt_d = is_last ? C_LONG_I : C_LONG;
                else         cnt_d = is_last ? C_EXEC_I : C_EXEC;
            end
            WAIT: if (cnt_q == '0) begin
                if (!is_last) begin
                    state_d = SETUP;
                    cnt_d   = C_SETUP;
                    rs_d    = 1'b0;
                    data_d  = init_rom(idx_q);
                    idx_d   = idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            IDLE: if (cmd_valid && ready_q) begin
                state_d = SETUP;
                cnt_d   = C_SETUP;
                rs_d    = cmd_rs;
                data_d  = cmd_data;
                ready_d = 1'b0;
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWRUP;
            cnt_q   <= C_PWRUP;
            idx_q   <= 3'd0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign init_done = done_q;
    assign lcd_en    = en_q;
    assign lcd_rs    = rs_q;
    assign lcd_data  = data_q;
    assign lcd_rw    = 1'b0;
    assign lcd_on    = 1'b1;
    assign lcd_blon  = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_tx.sv
// Directed bench for lcd_hd44780_tx with short timing parameters; every
// negedge sample also checks RW and EN-window bus stability.
module tb_lcd_hd44780_tx;
    localparam int TP = 10, TS = 1, TPU = 2, TH = 1, TE = 5, TL = 20;

    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, init_done, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon;
    logic [7:0] lcd_data;

    lcd_hd44780_tx #(.T_POWERUP(TP), .T_SETUP(TS), .T_PULSE(TPU), .T_HOLD(TH),
                     .T_EXEC(TE), .T_EXEC_LONG(TL)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .init_done(init_done), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data(lcd_data), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc_n = 0;
    logic       prev_en = 1'b0, hr = 1'b0;
    logic [7:0] hd = 8'h00;
    int guard = 0, rise_n = 0;
    int rlog[$], wlog[$];
    logic [7:0] dlog[$];
    logic rslog[$];
    logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Advance one cycle; sample after the falling edge and police the bus.
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        checks++;
        if (lcd_rw !== 1'b0) begin
            errors++; $display("FAIL rw_low: lcd_rw=%b required 0 (sample %0d)", lcd_rw, cyc_n);
        end
        if (rst) begin
            prev_en = 1'b0; guard = 0;
        end else begin
            if (lcd_en && !prev_en) begin
                hd = lcd_data; hr = lcd_rs; rise_n = cyc_n;
                rlog.push_back(cyc_n); dlog.push_back(lcd_data); rslog.push_back(lcd_rs);
            end else if (lcd_en || guard > 0) begin
                checks++;
                if (lcd_data !== hd || lcd_rs !== hr) begin
                    errors++;
                    $display("FAIL bus_stable: data=%h rs=%b required data=%h rs=%b (sample %0d)",
                             lcd_data, lcd_rs, hd, hr, cyc_n);
                end
            end
            if (!lcd_en && prev_en) wlog.push_back(cyc_n - rise_n);
            guard = lcd_en ? TH : ((guard > 0) ? guard - 1 : 0);
            prev_en = lcd_en;
        end
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready === 1'b1) begin n = cyc_n; break; end
            tick();
        end
        checks++;
        if (n < 0) begin errors++; $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int k);
        k = -1;
        cmd_rs = rs; cmd_data = d; cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready === 1'b1) begin tick(); k = cyc_n; break; end
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (k < 0) begin errors++; $display("FAIL accept_timeout: no accept of %h, required one", d); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, init_done, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon} !== 7'b0000011) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/done/en/rs/rw/on/blon=%b required 0000011",
                     {cmd_ready, init_done, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon});
        end
        checks++;
        if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: %h required 00", lcd_data); end
    endtask

    // Releases rst (held high on entry) and checks the whole init replay.
    task automatic test_init();
        int base, n;
        rlog.delete(); wlog.delete(); dlog.delete(); rslog.delete();
        base = cyc_n;
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n - base != 78) begin  // high ahead of edge 79 after release
            errors++; $display("FAIL init_ready_time: %0d required 78", n - base);
        end
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: %b required 1", init_done); end
        checks++;
        if (rlog.size() != 6 || wlog.size() != 6) begin
            errors++; $display("FAIL init_pulses: rises=%0d falls=%0d required 6", rlog.size(), wlog.size());
        end else begin
            checks++;
            if (rlog[0] - base != TP + TS) begin
                errors++; $display("FAIL init_first_en: %0d required %0d", rlog[0] - base, TP + TS);
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (dlog[i] !== rom[i] || rslog[i] !== 1'b0 || wlog[i] != TPU) begin
                    errors++;
                    $display("FAIL init_byte%0d: data=%h rs=%b width=%0d required %h 0 %0d",
                             i, dlog[i], rslog[i], wlog[i], rom[i], TPU);
                end
            end
        end
    endtask

    task automatic test_char();
        int k, n;
        send(1'b1, 8'h41, k);
        checks++;
        if (lcd_data !== 8'h41 || lcd_rs !== 1'b1 || cmd_ready !== 1'b0 || lcd_en !== 1'b0) begin
            errors++;
            $display("FAIL char_accept: data=%h rs=%b rdy=%b en=%b required 41 1 0 0",
                     lcd_data, lcd_rs, cmd_ready, lcd_en);
        end
        for (int off = 1; off <= 3; off++) begin
            tick();
            checks++;
            if (lcd_en !== (off <= 2)) begin
                errors++; $display("FAIL char_en_off%0d: %b required %b", off, lcd_en, off <= 2);
            end
        end
        wait_ready(n);
        checks++;
        if (n - k != 8) begin errors++; $display("FAIL char_ready_time: %0d required 8", n - k); end
    endtask

    task automatic test_long();
        int k, n;
        send(1'b0, 8'h01, k);
        wait_ready(n);
        checks++;
        if (n - k != 23) begin errors++; $display("FAIL long_clear_time: %0d required 23", n - k); end
        send(1'b1, 8'h01, k);
        wait_ready(n);
        checks++;
        if (n - k != 8) begin errors++; $display("FAIL data01_time: %0d required 8", n - k); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [3] = '{8'h48, 8'h49, 8'h21};
        int acc [3];
        logic pr;
        cmd_rs = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_data = b[i];
            acc[i] = -1;
            for (int t = 0; t < 60; t++) begin
                pr = cmd_ready;
                tick();
                if (pr === 1'b1) begin acc[i] = cyc_n; break; end
            end
            checks++;
            if (acc[i] < 0 || lcd_data !== b[i] || lcd_rs !== 1'b1) begin
                errors++; $display("FAIL b2b_accept%0d: data=%h rs=%b required %h 1", i, lcd_data, lcd_rs, b[i]);
            end
            cmd_data = 8'hEE;
            repeat (3) tick();
            checks++;
            if (lcd_data !== b[i]) begin
                errors++; $display("FAIL b2b_busy_ignore%0d: data=%h required %h", i, lcd_data, b[i]);
            end
        end
        cmd_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 9) begin
                errors++; $display("FAIL b2b_spacing%0d: %0d required 9", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int k, n;
        wait_ready(n);
        send(1'b1, 8'h55, k);
        tick();
        checks++;
        if (lcd_en !== 1'b1) begin errors++; $display("FAIL rst_pre_en: %b required 1", lcd_en); end
        rst = 1'b1; cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h77;
        tick();
        checks++;
        if (lcd_en !== 1'b0 || cmd_ready !== 1'b0 || init_done !== 1'b0 || lcd_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid: en=%b rdy=%b done=%b data=%h required 0 0 0 00",
                     lcd_en, cmd_ready, init_done, lcd_data);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b0 || lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin
            errors++;
            $display("FAIL rst_wins: rdy=%b data=%h rs=%b required 0 00 0", cmd_ready, lcd_data, lcd_rs);
        end
        cmd_valid = 1'b0;
        test_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_long();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
